// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_cla_adder
// Description : WIDTH-bit add/subtract, one GROUP-bit carry-lookahead slice
//               per pipeline stage, valid/ready flow control with full stall.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int STAGES = WIDTH / GROUP;
  localparam int LAST   = STAGES - 1;
  localparam int MSB    = WIDTH - 1;

  // Operands travel whole; stage k fills in sum slice k and replaces the carry.
  typedef struct packed {
    logic             valid;
    logic             sub;
    logic             carry;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
  } stage_t;

  stage_t front;
  stage_t nxt  [STAGES];
  stage_t pipe [STAGES];
  logic   stall;

  // Flattened lookahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
  function automatic logic [GROUP:0] lookahead(
    input logic [GROUP-1:0] g,
    input logic [GROUP-1:0] p,
    input logic             cin
  );
    logic [GROUP:0] c;
    logic           term;
    c[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      c[i+1] = g[i];
      term   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (term & g[j]);
        term   = term & p[j];
      end
      c[i+1] = c[i+1] | (term & cin);
    end
    return c;
  endfunction

  function automatic stage_t step(input stage_t s, input int k);
    logic [GROUP-1:0] ga;
    logic [GROUP-1:0] gb;
    logic [GROUP:0]   c;
    stage_t           r;
    ga = s.a[k*GROUP +: GROUP];
    gb = s.b[k*GROUP +: GROUP];
    c  = lookahead(ga & gb, ga ^ gb, s.carry);
    r  = s;
    r.sum[k*GROUP +: GROUP] = ga ^ gb ^ c[GROUP-1:0];
    r.carry = c[GROUP];
    return r;
  endfunction

  always_comb begin
    front       = '0;
    front.valid = in_valid;
    front.sub   = Sub;
    front.carry = Sub ? 1'b1 : Cin;
    front.a     = A;
    front.b     = Sub ? ~B : B;
  end

  always_comb begin
    nxt[0] = step(front, 0);
    for (int k = 1; k < STAGES; k++) begin
      nxt[k] = step(pipe[k-1], k);
    end
  end

  assign stall    = pipe[LAST].valid && !out_ready;
  assign in_ready = !stall;

  // The whole pipe freezes on stall, so bubbles keep their slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        pipe[k] <= '0;
      end
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        pipe[k] <= nxt[k];
      end
    end
  end

  assign out_valid = pipe[LAST].valid;
  assign Sum       = pipe[LAST].sum;
  assign Cout      = pipe[LAST].carry;
  assign Ovf       = (pipe[LAST].a[MSB] == pipe[LAST].b[MSB]) &&
                     (pipe[LAST].sum[MSB] != pipe[LAST].a[MSB]);

endmodule
`default_nettype wire

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand and sum width in bits.
REQ-002 The block SHALL have parameter GROUP, default 4, meaning the bits per carry-lookahead group and per pipeline stage; WIDTH SHALL be a multiple of GROUP, and STAGES = WIDTH/GROUP.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port A, input, WIDTH bits: operand A.
REQ-006 The block SHALL have port B, input, WIDTH bits: operand B.
REQ-007 The block SHALL have port Cin, input, 1 bit: carry in, used only when Sub=0.
REQ-008 The block SHALL have port Sub, input, 1 bit: mode select, 0 = A+B+Cin, 1 = A-B (computed as A+~B+1).
REQ-009 The block SHALL have port in_valid, input, 1 bit: the operand set is valid.
REQ-010 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand set this cycle.
REQ-011 The block SHALL have port Sum, output, WIDTH bits: the result.
REQ-012 The block SHALL have port Cout, output, 1 bit: carry out of the MSB; when Sub=1, a value of 1 means no borrow.
REQ-013 The block SHALL have port Ovf, output, 1 bit: two's-complement signed overflow of the result.
REQ-014 The block SHALL have port out_valid, output, 1 bit: Sum, Cout and Ovf are valid.
REQ-015 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.

Function
REQ-016 Transfer SHALL occur on the input side when in_valid && in_ready, and on the output side when out_valid && out_ready.
REQ-017 Stage k (k = 0..STAGES-1) SHALL compute bits [k*GROUP +: GROUP] with a GROUP-bit carry-lookahead block (generate/propagate per bit, lookahead carries, group carry out) and SHALL register that slice, the group carry and a stage valid bit.
REQ-018 The carry into stage 0 SHALL be Sub ? 1 : Cin; the carry into stage k>0 SHALL be the registered group carry of stage k-1 for the same transaction.
REQ-019 The unprocessed upper operand bits and Sub SHALL travel with the transaction through the stage registers; the B inversion SHALL be applied before stage 0 is registered.
REQ-020 Latency SHALL be exactly STAGES cycles from input transfer to out_valid=1 when there is no stall (16/4 -> 4 cycles).
REQ-021 Throughput SHALL be one transaction per cycle when out_ready=1 continuously.
REQ-022 Stall SHALL be defined as out_valid && !out_ready; during a stall all stage registers, including valid bits, SHALL hold.
REQ-023 in_ready SHALL equal !stall, which is combinational from out_ready and the registered out_valid.
REQ-024 Bubbles SHALL propagate: a stage whose valid bit is 0 carries no transaction, and bubbles SHALL NOT be collapsed during a stall.
REQ-025 Cout SHALL be the carry out of the last group, and Ovf SHALL equal (A[MSB]==B'[MSB]) && (Sum[MSB]!=A[MSB]), where B' is the effective B after optional inversion.
REQ-026 Results SHALL wrap modulo 2^WIDTH, and results SHALL leave in the same order the operands were accepted.
REQ-027 Sum, Cout and Ovf SHALL be stable while out_valid && !out_ready.

Reset
REQ-028 When rst_n=0, all stage valid bits SHALL clear immediately, regardless of clk.
REQ-029 While rst_n=0, Sum=0, Cout=0, Ovf=0, out_valid=0, and in_ready=1.
REQ-030 Any transaction in flight when reset asserts SHALL be discarded; the first accept after rst_n rises SHALL produce a correct result after STAGES cycles.

Verification
REQ-031 Bench scenario, add with carry: A=16'h00FF, B=16'h0001, Cin=0, Sub=0 -> 4 cycles later Sum=16'h0100, Cout=0, Ovf=0.
REQ-032 Bench scenario, full carry chain: A=16'hFFFF, B=16'h0000, Cin=1 -> Sum=16'h0000, Cout=1, Ovf=0.
REQ-033 Bench scenario, signed overflow and subtract: first A=16'h7FFF, B=16'h0001, Sub=0 -> Sum=16'h8000, Ovf=1, Cout=0; then A=16'h0003, B=16'h0005, Sub=1 -> Sum=16'hFFFE, Cout=0, Ovf=0.
REQ-034 Bench scenario, back-to-back stream: 8 consecutive transfers with out_ready=1 -> 8 consecutive out_valid cycles, in order, with results matching a reference model.
REQ-035 Bench scenario, backpressure: out_ready=0 for 5 cycles with the pipe full -> in_ready=0 and outputs held; on release, no loss or duplication.
REQ-036 Bench scenario, reset mid-stream: assert rst_n=0 between clock edges with 3 transactions in flight -> out_valid=0 immediately, and no stale results after release.
